// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    // Column drive is one-cold; column 0 is driven first out of reset.
    localparam logic [3:0] COLS_RESET = 4'b1110;

    // Hex code of the key at (row, col) on the physical keypad legend.
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] k;
        k = 4'h0;
        case ({row_idx, col_idx})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Index of the lowest-numbered zero bit (row or column that is active).
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and decoded-digit bundle between scanner, keypad and display.
// Latency: none (wires only).
// Backpressure: none; key_valid is a fire-and-forget pulse.
// master: scanner side (samples rows, drives cols and digits).
// slave : keypad/display side.
interface keypad_scanner_if;
    logic [3:0] rows;       // active-low row lines, asynchronous
    logic [3:0] cols;       // one-cold column drive
    logic [3:0] digit_new;  // most recent key code
    logic [3:0] digit_old;  // key code before digit_new
    logic       key_valid;  // one-cycle pulse on acceptance

    modport master (
        input  rows,
        output cols,
        output digit_new,
        output digit_old,
        output key_valid
    );

    modport slave (
        output rows,
        input  cols,
        input  digit_new,
        input  digit_old,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, resets to all-ones.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, reset (async active-low), d (async in), q (synchronized out).
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces presses/releases, keeps last two key codes.
// Latency: 2 clk sync + first detecting tick + DEBOUNCE_CNT ticks to key_valid.
// Backpressure: none; key_valid is a single-cycle pulse that cannot be stalled.
// Ports: clk, reset (async active-low), kp (master: rows in, cols/digits/key_valid out).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 24000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    logic [3:0]    rs;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    scan_state_t   state, state_nxt;
    logic [3:0]    cols_q;
    logic [1:0]    row_sel;
    logic [DW-1:0] db_cnt;
    logic [3:0]    digit_new_q, digit_old_q;
    logic          row_low;
    logic          any_low;
    logic          db_last;

    // Output-comb controls
    logic key_valid_c;
    logic col_adv;
    logic latch_key;
    logic db_clr;
    logic db_inc;

    sync2 #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.rows),
        .q     (rs)
    );

    // Free-running scan tick; never cleared by the FSM so tick spacing is exact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick    = (tick_cnt == TICK_LAST);
    assign row_low = ~rs[row_sel];
    assign any_low = (rs != 4'hF);
    assign db_last = (db_cnt == DB_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; all transitions happen only on tick.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                SCAN:       if (any_low) state_nxt = PRESS_DB;
                PRESS_DB: begin
                    if (!row_low)     state_nxt = SCAN;
                    else if (db_last) state_nxt = HOLD;
                end
                HOLD:       if (!row_low) state_nxt = RELEASE_DB;
                RELEASE_DB: begin
                    // A low sample here is bounce on release: back to HOLD, never a new key.
                    if (row_low)      state_nxt = HOLD;
                    else if (db_last) state_nxt = SCAN;
                end
                default:    state_nxt = SCAN;
            endcase
        end
    end

    // Output / datapath control logic
    always_comb begin
        key_valid_c = 1'b0;
        col_adv     = 1'b0;
        latch_key   = 1'b0;
        db_clr      = 1'b0;
        db_inc      = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    latch_key = any_low;
                    db_clr    = any_low;
                    col_adv   = ~any_low;
                end
                PRESS_DB: begin
                    db_inc      = row_low;
                    key_valid_c = row_low & db_last;
                    col_adv     = ~row_low;
                end
                HOLD: begin
                    db_clr = ~row_low;
                end
                RELEASE_DB: begin
                    db_inc  = ~row_low;
                    col_adv = ~row_low & db_last;
                end
                default: ;
            endcase
        end
    end

    // Column drive, latched row, debounce count and digit history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_q      <= COLS_RESET;
            row_sel     <= 2'd0;
            db_cnt      <= '0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            if (col_adv) begin
                cols_q <= {cols_q[2:0], cols_q[3]};
            end
            if (latch_key) begin
                row_sel <= low_idx(rs);
            end
            if (db_clr) begin
                db_cnt <= '0;
            end else if (db_inc) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (key_valid_c) begin
                digit_old_q <= digit_new_q;
                digit_new_q <= keymap(row_sel, low_idx(cols_q));
            end
        end
    end

    assign kp.cols      = cols_q;
    assign kp.digit_new = digit_new_q;
    assign kp.digit_old = digit_old_q;
    assign kp.key_valid = key_valid_c;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad model + tick-level reference.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    localparam int M_SCAN  = 0;
    localparam int M_PRESS = 1;
    localparam int M_HOLD  = 2;
    localparam int M_REL   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Physical keypad: pressed[r*4+c]; a pressed key pulls its row low while its column is driven.
    bit         pressed [16];
    logic [3:0] rows_drv;
    always_comb begin
        rows_drv = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i] && kp.cols[i % 4] == 1'b0) rows_drv[i / 4] = 1'b0;
        end
    end
    assign kp.rows = rows_drv;

    logic [3:0] keytab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    int checks = 0;
    int failures = 0;
    int seen_pulses = 0;

    // Reference model state: what the block holds after the latest clock edge.
    logic [3:0] m_s1, m_s2;
    int m_tc, m_mode, m_col, m_row, m_db;
    logic [3:0] m_new, m_old;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_tc = 0; m_mode = M_SCAN; m_col = 0; m_row = 0; m_db = 0;
        m_new = 4'h0; m_old = 4'h0;
    endtask

    function automatic logic [3:0] model_cols();
        logic [3:0] c;
        c = 4'hF;
        c[m_col] = 1'b0;
        return c;
    endfunction

    function automatic bit model_kv();
        return (m_mode == M_PRESS) && (m_tc == SD - 1) && (m_s2[m_row] == 1'b0) && (m_db == DB - 1);
    endfunction

    // Advance one clock using the rows value the block will sample.
    task automatic model_step(input logic [3:0] rows_now);
        bit tick;
        bit low;
        tick = (m_tc == SD - 1);
        low  = (m_s2[m_row] == 1'b0);
        if (model_kv()) begin
            m_old = m_new;
            m_new = keytab[m_row * 4 + m_col];
        end
        if (tick) begin
            case (m_mode)
                M_SCAN: begin
                    if (m_s2 != 4'hF) begin
                        for (int r = 3; r >= 0; r--) if (!m_s2[r]) m_row = r;
                        m_db = 0;
                        m_mode = M_PRESS;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
                M_PRESS: begin
                    if (!low) begin
                        m_mode = M_SCAN;
                        m_col = (m_col + 1) % 4;
                    end else begin
                        m_db++;
                        if (m_db == DB) m_mode = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (!low) begin
                        m_db = 0;
                        m_mode = M_REL;
                    end
                end
                default: begin
                    if (low) begin
                        m_mode = M_HOLD;
                    end else begin
                        m_db++;
                        if (m_db == DB) begin
                            m_mode = M_SCAN;
                            m_col = (m_col + 1) % 4;
                        end
                    end
                end
            endcase
        end
        m_tc = tick ? 0 : m_tc + 1;
        m_s2 = m_s1;
        m_s1 = rows_now;
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!reset) model_reset();
        chk("cols", kp.cols, model_cols());
        chk("key_valid", kp.key_valid, model_kv());
        chk("digit_new", kp.digit_new, m_new);
        chk("digit_old", kp.digit_old, m_old);
        if (kp.key_valid === 1'b1) seen_pulses++;
        if (reset) model_step(kp.rows);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int max_cyc);
        int start;
        start = seen_pulses;
        for (int i = 0; i < max_cyc; i++) begin
            if (seen_pulses != start) break;
            cyc(1);
        end
        chk(name, (seen_pulses != start), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [$];
        logic [3:0] exp_seq [5];
        int p0;
        int found;

        release_all();
        reset = 1'b0;
        model_reset();
        cyc(3);
        reset = 1'b1;

        // 1: idle rotation
        chk("reset_cols", kp.cols, 4'b1110);
        seq.push_back(kp.cols);
        for (int i = 0; i < 17; i++) begin
            cyc(1);
            if (kp.cols != seq[$]) seq.push_back(kp.cols);
            if (i == 3) chk("first_rotate", kp.cols, 4'b1101);
        end
        exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        chk("rot_len", seq.size(), 5);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rot_seq", seq[i], exp_seq[i]);
        chk("idle_pulses", seen_pulses, 0);
        chk("idle_digit", kp.digit_new, 4'h0);

        // 2: key 5 then key 9
        p0 = seen_pulses;
        pressed[5] = 1'b1;
        wait_pulse("pulse_5", 200);
        cyc(2);
        chk("lit_new_5", kp.digit_new, 4'h5);
        chk("lit_old_0", kp.digit_old, 4'h0);
        release_all();
        cyc(60);
        pressed[10] = 1'b1;
        wait_pulse("pulse_9", 200);
        cyc(2);
        chk("lit_new_9", kp.digit_new, 4'h9);
        chk("lit_old_5", kp.digit_old, 4'h5);
        release_all();
        cyc(60);
        chk("pulses_5_9", seen_pulses - p0, 2);

        // 3: key 0 bouncing on alternate ticks, then stable
        p0 = seen_pulses;
        for (int i = 0; i < 10; i++) begin
            pressed[13] = ~pressed[13];
            cyc(SD);
        end
        chk("bounce_pulses", seen_pulses - p0, 0);
        pressed[13] = 1'b1;
        wait_pulse("pulse_0", 200);
        cyc(2);
        chk("lit_new_0", kp.digit_new, 4'h0);
        chk("lit_old_9", kp.digit_old, 4'h9);
        release_all();
        cyc(60);

        // 4: hold A, add 1 in the same row
        p0 = seen_pulses;
        pressed[3] = 1'b1;
        wait_pulse("pulse_A", 200);
        pressed[0] = 1'b1;
        cyc(40);
        chk("hold_pulses", seen_pulses - p0, 1);
        release_all();
        cyc(60);
        chk("after_rel_pulses", seen_pulses - p0, 1);
        chk("lit_new_A", kp.digit_new, 4'hA);

        // 5: release bounce on key 7
        p0 = seen_pulses;
        pressed[8] = 1'b1;
        wait_pulse("pulse_7", 200);
        cyc(12);
        pressed[8] = 1'b0;
        cyc(6);
        pressed[8] = 1'b1;
        cyc(8);
        pressed[8] = 1'b0;
        cyc(60);
        chk("rel_bounce_pulses", seen_pulses - p0, 1);
        chk("lit_new_7", kp.digit_new, 4'h7);

        // 6: reset in the middle of press debounce
        pressed[6] = 1'b1;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_mode == M_PRESS && m_db == 2) begin
                found = 1;
                break;
            end
            cyc(1);
        end
        chk("reach_db2", found, 1);
        reset = 1'b0;
        release_all();
        #1;
        chk("rst_mid_cols", kp.cols, 4'b1110);
        chk("rst_mid_new", kp.digit_new, 4'h0);
        chk("rst_mid_old", kp.digit_old, 4'h0);
        chk("rst_mid_kv", kp.key_valid, 1'b0);
        cyc(3);
        reset = 1'b1;
        p0 = seen_pulses;
        cyc(40);
        chk("post_rst_pulses", seen_pulses - p0, 0);

        // Random phase: random keys, hold times, second keys and bounces
        for (int it = 0; it < 40; it++) begin
            pressed[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
            cyc($urandom_range(1, 60));
            if ($urandom_range(0, 2) == 0) begin
                for (int b = 0; b < 4; b++) begin
                    pressed[$urandom_range(0, 15)] = ($urandom_range(0, 1) == 1);
                    cyc($urandom_range(1, 6));
                end
            end
            release_all();
            cyc($urandom_range(1, 60));
        end
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and decodes presses into hexadecimal digits for the dual seven-segment display path. It is the input end of the display interface: the time-multiplexed display shows two hex digits, and this block supplies them as the two most recent debounced key presses. It sits between the keypad pins and the display controller, with one decoded key registered per physical press.

## Interface
- SCAN_DIV, default 24000: clk cycles per scan tick (about 1 ms at 24 MHz).
- DEBOUNCE_CNT, default 20: consecutive stable scan ticks required to accept a press or a release.
- clk  in  1  system clock; all state is in this domain.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  keypad row lines, active-low (external pull-ups), asynchronous to clk.
- cols  out  4  column drive, one-cold: exactly one bit is 0 at all times.
- digit_new  out  4  most recently accepted key code.
- digit_old  out  4  key code accepted before digit_new.
- key_valid  out  1  one-cycle pulse when a new key is accepted.

## Operation
- rows pass through a 2-flop synchronizer. All decisions use the synchronized value rs.
- A tick counter counts 0 to SCAN_DIV-1 and raises tick for one cycle at terminal count. It runs freely and is never reset except by reset.
- Key map, indexed by row r and column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: SCAN, PRESS_DB, HOLD, RELEASE_DB.
- SCAN:
  - On tick, if rs != 4'hF: latch active column and row (lowest-index low row wins), clear debounce count, go to PRESS_DB. cols do not change.
  - Otherwise, on tick, rotate cols to the next column (1110 → 1101 → 1011 → 0111 → 1110).
- PRESS_DB:
  - On tick, if the latched row is still low: increment count.
  - On reaching DEBOUNCE_CNT: digit_old <= digit_new, digit_new <= decoded key, key_valid = 1 for that cycle, go to HOLD.
  - On tick, if the latched row is high: return to SCAN and advance cols to the next column on the same tick.
- HOLD: cols stay locked. Other keys, including other rows in the same column, are ignored. On tick with the latched row high, clear count and go to RELEASE_DB.
- RELEASE_DB:
  - On tick with the latched row high: increment count.
  - On reaching DEBOUNCE_CNT: go to SCAN and advance cols.
  - On tick with the latched row low: return to HOLD. No new key is accepted; a bounce is never a second press.
- Reset values: state SCAN, cols 4'b1110, digit_new 0, digit_old 0, key_valid 0, counters 0, synchronizer flops 1.

## Timing
- Synchronizer latency is 2 clk cycles from a rows change to rs.
- cols change only on tick, so rows are sampled a full SCAN_DIV after the column switch to allow settling.
- Press latency: first tick seeing rs low, plus DEBOUNCE_CNT further ticks. key_valid is asserted in the cycle of the accepting tick. digit_new and digit_old update on the following clock edge.
- key_valid is exactly one clk wide and is never asserted on consecutive cycles.
- Simultaneous press in a different column during HOLD: ignored until release completes. It is then detected when the scan reaches that column.
- Reset asserted mid-debounce: all state returns to reset values immediately; the pending key is discarded.

## Structure
- Package keypad_pkg:
  - state enum scan_state_t.
  - function keymap(row_idx, col_idx) returning logic [3:0].
  - localparams for the column one-cold reset value.
- One sub-module, sync2: parameterized-width 2-flop synchronizer with async active-low reset to all-ones.
- Tick counter, FSM, and digit registers live in keypad_scanner.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset released, rows=4'hF → cols rotate 1110→1101→1011→0111→1110 every 4 cycles; key_valid stays 0; digits stay 0.
2. Hold row1 low only while cols=1101 (key 5), stable → exactly one key_valid pulse; digit_new=5, digit_old=0. Then key 9 → digit_new=9, digit_old=5.
3. Key 0 (r3, c1) bounces low/high on alternate ticks for 10 ticks, then stays low → no pulse during bouncing; one pulse after 3 stable ticks; digit_new=0.
4. Hold A (r0, c3), then also press 1 (r0, c0) → single pulse for A. After both are released for 3 ticks, 1 is not reported unless still held.
5. Release bounce: after accepting 7, toggle row2 once during RELEASE_DB → returns to HOLD; no second pulse; digit_new=7.
6. Assert reset during PRESS_DB at count 2 → cols=1110, digits=0, no key_valid after reset deasserts with rows=4'hF.
